vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port VRAM arbiter and frame-clear sequencer for the GPU board. It shares one registered-output block RAM framebuffer between three sources: VGA scanout reads (highest priority), rasterizer reads/writes, and an internal clear engine that fills the framebuffer with a solid colour. It sits between the VGA timing/scanout unit, the raster core, and the VRAM macro inside the board top.

## Interface
- `ADDR_W`, 17 — VRAM word address width.
- `DATA_W`, 12 — pixel word width (4-bit R, G, B).
- `FB_WORDS`, 76800 — words written by one clear (320×240).
- `STARVE_LIMIT`, 8 — raster wait cycles before forced grant (guard builds only).

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `sc_req` in 1 — scanout read request.
- `sc_addr` in ADDR_W — scanout read address.
- `sc_gnt` out 1 — scanout access issued this cycle.
- `sc_rvalid` out 1 — scanout read data valid.
- `sc_rdata` out DATA_W — scanout read data.
- `rs_req` in 1 — raster request.
- `rs_we` in 1 — raster write (1) / read (0).
- `rs_addr` in ADDR_W — raster address.
- `rs_wdata` in DATA_W — raster write data.
- `rs_gnt` out 1 — raster access issued this cycle.
- `rs_rvalid` out 1 — raster read data valid.
- `rs_rdata` out DATA_W — raster read data.
- `clr_start` in 1 — start a framebuffer clear.
- `clr_color` in DATA_W — clear colour, sampled on accepted start.
- `clr_busy` out 1 — clear in progress.
- `clr_done` out 1 — one-cycle pulse when the clear completes.
- `mem_en`, `mem_we` out 1 — VRAM enable and write strobe.
- `mem_addr` out ADDR_W — VRAM address.
- `mem_wdata` out DATA_W — VRAM write data.
- `mem_rdata` in DATA_W — VRAM read data, valid 1 cycle after a read enable.

## Operation
- Requesters hold `*_req`, address, `rs_we` and `rs_wdata` stable until they see `*_gnt`. Each `*_gnt` is a 1-cycle pulse per access. A requester may keep `req` high to issue back-to-back accesses.
- Priority each cycle: scanout > raster > clear. At most one grant per cycle.
- `mem_*` are driven combinationally from the winner. With no winner, `mem_en`=0 and `mem_we`=0.
- Clear engine states:
  - IDLE: `clr_start` latches `clr_color`, sets the counter to 0, and moves to FILL.
  - FILL: in each cycle with no scanout or raster grant, the engine writes `clr_color` to address = counter and increments the counter. After the write to `FB_WORDS-1`, it returns to IDLE.
  - `clr_start` while in FILL is ignored.
- Read return: `sc_rvalid`/`rs_rvalid` is registered high exactly one cycle after a read grant to that port. Write grants never produce `rvalid`.
- `sc_rdata` and `rs_rdata` both mirror `mem_rdata` continuously. They are meaningful only while the matching `rvalid` is high.

## Timing
- Grant latency is 0 cycles: `gnt` rises in the same cycle as `req` when that port wins.
- Read data latency is 1 cycle after `gnt`.
- Reset values: all `gnt`, `rvalid`, `clr_busy`, `clr_done`, `mem_en` and `mem_we` are 0. `mem_addr` and `mem_wdata` are 0. `rdata` follows `mem_rdata`.
- While `reset` is high, no grants are issued.
- `clr_busy` is 1 from the cycle after an accepted `clr_start` until the cycle after the final write. In that cycle, `clr_busy` falls and `clr_done` pulses for 1 cycle.
- Reset during FILL aborts the clear: counter cleared, no `clr_done`.
- A clear is preemptible at every word; no word is skipped or written twice.
- `rvalid` for a grant issued in the cycle `reset` rises is suppressed.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - A counter tracks consecutive cycles with `rs_req`=1 and `rs_gnt`=0.
  - When it reaches `STARVE_LIMIT`, raster beats scanout on the next cycle, and the counter clears.
  - The counter also clears on any raster grant, when `rs_req`=0, and on reset.
- Undefined: strict fixed priority. Raster may starve indefinitely under continuous scanout.

## Test plan
- Reset, then `sc_req`=1 with `sc_addr`=5 and preloaded word 0xABC → `sc_gnt` in the same cycle; next cycle `sc_rvalid`=1 and `sc_rdata`=0xABC.
- `sc_req` and `rs_req` (write, addr 9, 0x123) together for one cycle, then scanout drops → scanout granted first, raster granted the following cycle, memory word 9 = 0x123.
- `clr_start` with `clr_color`=0xF00 and no other traffic → `clr_busy` for 76800 cycles, `clr_done` pulse, all words = 0xF00.
- Clear interrupted by a 10-cycle raster read burst mid-fill → every word is still written exactly once (write-address log has no gaps or duplicates), raster reads return correct data, and `clr_done` is delayed by exactly 10 cycles.
- Guard build, continuous `sc_req` plus `rs_req` → `rs_gnt` every 9th cycle. Non-guard build → `rs_gnt` never rises.
- `reset` asserted mid-clear at word 1000 → `clr_busy`=0 next cycle and no `clr_done`. A new `clr_start` restarts from address 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter (scanout > raster > clear) with a preemptible frame-clear engine.
// Optional raster starvation guard is enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned FB_WORDS     = 76800,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] sc_addr,
    output logic              sc_gnt,
    output logic              sc_rvalid,
    output logic [DATA_W-1:0] sc_rdata,
    input  logic              rs_req,
    input  logic              rs_we,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_wdata,
    output logic              rs_gnt,
    output logic              rs_rvalid,
    output logic [DATA_W-1:0] rs_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_WORDS - 1);

    typedef enum logic [0:0] {StIdle, StFill} clr_state_e;

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_color;
    logic              r_clr_busy;
    logic              r_clr_done;
    logic              r_sc_rvalid;
    logic              r_rs_rvalid;

    logic              w_rs_first;
    logic              w_sc_gnt;
    logic              w_rs_gnt;
    logic              w_clr_we;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] r_starve;

    // Once the raster has waited STARVE_LIMIT cycles it outranks scanout for one cycle.
    assign w_rs_first = (r_starve == StarveW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset || !rs_req || w_rs_gnt) begin
            r_starve <= '0;
        end else if (!w_rs_first) begin
            r_starve <= r_starve + StarveW'(1);
        end
    end
`else
    assign w_rs_first = 1'b0;
`endif

    always_comb begin
        w_sc_gnt = !reset && sc_req && !(w_rs_first && rs_req);
        w_rs_gnt = !reset && rs_req && !w_sc_gnt;
        w_clr_we = !reset && (r_state == StFill) && !w_sc_gnt && !w_rs_gnt;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_sc_gnt) begin
            mem_en   = 1'b1;
            mem_addr = sc_addr;
        end else if (w_rs_gnt) begin
            mem_en    = 1'b1;
            mem_we    = rs_we;
            mem_addr  = rs_addr;
            mem_wdata = rs_wdata;
        end else if (w_clr_we) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_cnt;
            mem_wdata = r_color;
        end
    end

    // Clear engine: the counter only advances on cycles where its write actually issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_color    <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (clr_start) begin
                        r_color    <= clr_color;
                        r_cnt      <= '0;
                        r_state    <= StFill;
                        r_clr_busy <= 1'b1;
                    end
                end
                StFill: begin
                    if (w_clr_we) begin
                        if (r_cnt == LastAddr) begin
                            r_cnt      <= '0;
                            r_state    <= StIdle;
                            r_clr_busy <= 1'b0;
                            r_clr_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc_rvalid <= 1'b0;
            r_rs_rvalid <= 1'b0;
        end else begin
            r_sc_rvalid <= w_sc_gnt;
            r_rs_rvalid <= w_rs_gnt && !rs_we;
        end
    end

    assign sc_gnt    = w_sc_gnt;
    assign rs_gnt    = w_rs_gnt;
    assign sc_rvalid = r_sc_rvalid;
    assign rs_rvalid = r_rs_rvalid;
    assign sc_rdata  = mem_rdata;
    assign rs_rdata  = mem_rdata;
    assign clr_busy  = r_clr_busy;
    assign clr_done  = r_clr_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small registered-output VRAM model.
// Uses a reduced framebuffer (256 words) so full clears stay short.
module tb_vram_arbiter;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned FB_WORDS = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sc_req = 1'b0;
    logic [ADDR_W-1:0] sc_addr = '0;
    logic              sc_gnt, sc_rvalid;
    logic [DATA_W-1:0] sc_rdata;
    logic              rs_req = 1'b0;
    logic              rs_we = 1'b0;
    logic [ADDR_W-1:0] rs_addr = '0;
    logic [DATA_W-1:0] rs_wdata = '0;
    logic              rs_gnt, rs_rvalid;
    logic [DATA_W-1:0] rs_rdata;
    logic              clr_start = 1'b0;
    logic [DATA_W-1:0] clr_color = '0;
    logic              clr_busy, clr_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];
    int                wr_cnt [0:(1<<ADDR_W)-1];
    logic              mon_en = 1'b0;
    int                busy_cycles = 0;
    int                done_cnt = 0;

    vram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FB_WORDS    (FB_WORDS),
        .STARVE_LIMIT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sc_req   (sc_req),
        .sc_addr  (sc_addr),
        .sc_gnt   (sc_gnt),
        .sc_rvalid(sc_rvalid),
        .sc_rdata (sc_rdata),
        .rs_req   (rs_req),
        .rs_we    (rs_we),
        .rs_addr  (rs_addr),
        .rs_wdata (rs_wdata),
        .rs_gnt   (rs_gnt),
        .rs_rvalid(rs_rvalid),
        .rs_rdata (rs_rdata),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
            if (mem_we && !rs_gnt && !sc_gnt) wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (clr_busy) busy_cycles++;
            if (clr_done) done_cnt++;
        end
    end

    task automatic clear_log();
        for (int a = 0; a < (1 << ADDR_W); a++) wr_cnt[a] = 0;
        busy_cycles = 0;
        done_cnt = 0;
    endtask

    task automatic start_clear(input logic [DATA_W-1:0] color);
        @(negedge clk);
        clr_start = 1'b1;
        clr_color = color;
        mon_en = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (clr_done) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: clr_done timeout, got none, required a pulse", name);
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic check_fill(input string name, input logic [DATA_W-1:0] color);
        int bad = 0;
        for (int a = 0; a < FB_WORDS; a++)
            if (wr_cnt[a] != 1 || vram[a] !== color) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL %s: bad words got %0d required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        sc_req = 1'b1; sc_addr = 10'd3;
        rs_req = 1'b1; rs_we = 1'b1; rs_addr = 10'd4; rs_wdata = 12'h555;
        clr_start = 1'b1; clr_color = 12'h111;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({sc_gnt, rs_gnt, mem_en, mem_we} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_grants: got %b required 0000", {sc_gnt, rs_gnt, mem_en, mem_we});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got %h/%h required 0/0", mem_addr, mem_wdata);
        end
        tests_run++;
        if ({sc_rvalid, rs_rvalid, clr_busy, clr_done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got %b required 0000",
                     {sc_rvalid, rs_rvalid, clr_busy, clr_done});
        end
        sc_req = 1'b0; rs_req = 1'b0; rs_we = 1'b0; clr_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({clr_busy, sc_rvalid, rs_rvalid} !== 3'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b required 000", {clr_busy, sc_rvalid, rs_rvalid});
        end
    endtask

    task automatic test_sc_read();
        vram[5] = 12'hABC;
        @(negedge clk);
        sc_req = 1'b1; sc_addr = 10'd5;
        #1;
        tests_run++;
        if ({sc_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 10'd5) begin
            tests_failed++;
            $display("FAIL sc_grant: got gnt/en/we %b addr %0d required 110 addr 5",
                     {sc_gnt, mem_en, mem_we}, mem_addr);
        end
        @(posedge clk);
        #1;
        sc_req = 1'b0;
        tests_run++;
        if (sc_rvalid !== 1'b1 || sc_rdata !== 12'hABC) begin
            tests_failed++;
            $display("FAIL sc_rdata: got v=%b d=%h required v=1 d=abc", sc_rvalid, sc_rdata);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (sc_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sc_rvalid_drop: got %b required 0", sc_rvalid);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        sc_req = 1'b1; sc_addr = 10'd20;
        rs_req = 1'b1; rs_we = 1'b1; rs_addr = 10'd9; rs_wdata = 12'h123;
        #1;
        tests_run++;
        if ({sc_gnt, rs_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL prio_first: got sc/rs %b required 10", {sc_gnt, rs_gnt});
        end
        @(posedge clk);
        #1 sc_req = 1'b0;
        #1;
        tests_run++;
        if ({sc_gnt, rs_gnt, mem_we} !== 3'b011 || mem_addr !== 10'd9 || mem_wdata !== 12'h123) begin
            tests_failed++;
            $display("FAIL prio_second: got sc/rs/we %b addr %0d data %h required 011 9 123",
                     {sc_gnt, rs_gnt, mem_we}, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1 rs_req = 1'b0; rs_we = 1'b0;
        tests_run++;
        if (vram[9] !== 12'h123 || rs_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_write: got word %h rvalid %b required 123 0", vram[9], rs_rvalid);
        end
    endtask

    task automatic test_clear();
        clear_log();
        start_clear(12'hF00);
        #1;
        tests_run++;
        if (clr_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_busy_rise: got %b required 1", clr_busy);
        end
        wait_done("clear_full");
        tests_run++;
        if (busy_cycles !== FB_WORDS || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL clear_timing: got busy %0d done %0d required %0d 1",
                     busy_cycles, done_cnt, FB_WORDS);
        end
        check_fill("clear_words", 12'hF00);
    endtask

    task automatic test_clear_preempt();
        for (int i = 0; i < 10; i++) vram[300 + i] = 12'h700 + 12'(i);
        clear_log();
        start_clear(12'h0A5);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rs_req = 1'b1; rs_we = 1'b0; rs_addr = 10'(300 + i);
            #1;
            tests_run++;
            if (rs_gnt !== 1'b1 || mem_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL preempt_gnt[%0d]: got gnt %b we %b required 1 0", i, rs_gnt, mem_we);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (rs_rvalid !== 1'b1 || rs_rdata !== 12'h700 + 12'(i)) begin
                tests_failed++;
                $display("FAIL preempt_rdata[%0d]: got v=%b d=%h required v=1 d=%h",
                         i, rs_rvalid, rs_rdata, 12'h700 + 12'(i));
            end
        end
        @(negedge clk);
        rs_req = 1'b0;
        wait_done("clear_preempt");
        tests_run++;
        if (busy_cycles !== FB_WORDS + 10 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL preempt_timing: got busy %0d done %0d required %0d 1",
                     busy_cycles, done_cnt, FB_WORDS + 10);
        end
        check_fill("preempt_words", 12'h0A5);
    endtask

    task automatic test_starvation();
        int n_rs = 0;
        bit exp_rs;
        @(negedge clk);
        sc_req = 1'b1; sc_addr = 10'd1;
        rs_req = 1'b1; rs_we = 1'b0; rs_addr = 10'd2;
        for (int c = 0; c < 40; c++) begin
            #1;
`ifdef VRAM_ARB_STARVE_GUARD_EN
            exp_rs = (c % 9 == 8);
`else
            exp_rs = 1'b0;
`endif
            tests_run++;
            if (rs_gnt !== exp_rs || sc_gnt !== !exp_rs) begin
                tests_failed++;
                $display("FAIL starve_cycle[%0d]: got rs/sc %b%b required %b%b",
                         c, rs_gnt, sc_gnt, exp_rs, !exp_rs);
            end
            if (rs_gnt === 1'b1) n_rs++;
            @(negedge clk);
        end
        sc_req = 1'b0; rs_req = 1'b0;
        tests_run++;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        if (n_rs !== 4) begin
`else
        if (n_rs !== 0) begin
`endif
            tests_failed++;
            $display("FAIL starve_total: got %0d raster grants", n_rs);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit found = 0;
        clear_log();
        start_clear(12'h3C3);
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_we === 1'b1 && mem_addr === 10'd100) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL abort_reach: got no write to word 100 required one");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: got busy %b done %b required 0 0", clr_busy, clr_done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (done_cnt !== 0 || clr_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done %0d busy %b required 0 0", done_cnt, clr_busy);
        end
        clear_log();
        start_clear(12'h0C3);
        #1;
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 12'h0C3) begin
            tests_failed++;
            $display("FAIL restart_addr: got we %b addr %0d data %h required 1 0 0c3",
                     mem_we, mem_addr, mem_wdata);
        end
        wait_done("restart");
        tests_run++;
        if (busy_cycles !== FB_WORDS || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL restart_timing: got busy %0d done %0d required %0d 1",
                     busy_cycles, done_cnt, FB_WORDS);
        end
        check_fill("restart_words", 12'h0C3);
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            vram[a] = '0;
            wr_cnt[a] = 0;
        end
        test_reset();
        test_sc_read();
        test_priority();
        test_clear();
        test_clear_preempt();
        test_starvation();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
